valid_out_stretcher: RTL

VALID_OUT_STRETCHER -- requirements
Module: valid_out_stretcher

---
 rtl/valid_out_stretcher.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/valid_out_stretcher.sv
`default_nettype none
// ============================================================================
// Module      : valid_out_stretcher
// Description : Stretches single-cycle valid_in pulses into HOLD_CYCLES-long
//               level_out windows separated by at least GAP_CYCLES low cycles.
//               Define VALID_OUT_QUEUE_EN to queue pulses that arrive while
//               busy; otherwise they are dropped and flagged in overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module valid_out_stretcher #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_W      = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  output logic              level_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [7:0] c_hold_last = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] c_gap_last  = 8'(GAP_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_count;
  logic [7:0] w_count_next;
  logic       r_level_out;
  logic       r_overflow;
  logic       w_overflow_next;
  logic       w_hold_last;
  logic       w_gap_last;
  logic       w_take_pending;
  logic       w_pulse_in_busy;
  logic       w_pend_full;
  logic       w_pend_any;

  assign w_hold_last = (r_count == c_hold_last);
  assign w_gap_last  = (r_count == c_gap_last);

  // A pulse on the final GAP cycle restarts HOLD directly, so it is never
  // treated as a queued or lost pulse.
  assign w_pulse_in_busy = valid_in && (r_state != IDLE) &&
                           !((r_state == GAP) && w_gap_last);

`ifdef VALID_OUT_QUEUE_EN
  logic [PEND_W-1:0] r_pending;
  logic [PEND_W-1:0] w_pending_next;

  assign w_pend_full = &r_pending;
  assign w_pend_any  = |r_pending;

  always_comb begin
    w_pending_next = r_pending;
    if (w_pulse_in_busy && !w_pend_full) begin
      w_pending_next = r_pending + PEND_W'(1);
    end else if (w_take_pending) begin
      w_pending_next = r_pending - PEND_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_next;
    end
  end

  assign pending = r_pending;
`else
  assign w_pend_full = 1'b1;
  assign w_pend_any  = 1'b0;
  assign pending     = '0;
`endif

  assign w_overflow_next = r_overflow | (w_pulse_in_busy & w_pend_full);

  always_comb begin
    w_state_next   = r_state;
    w_count_next   = r_count;
    w_take_pending = 1'b0;
    case (r_state)
      IDLE: begin
        w_count_next = 8'd0;
        if (valid_in) begin
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        if (w_hold_last) begin
          w_state_next = GAP;
          w_count_next = 8'd0;
        end else begin
          w_count_next = r_count + 8'd1;
        end
      end
      GAP: begin
        if (w_gap_last) begin
          w_count_next = 8'd0;
          if (valid_in) begin
            w_state_next = HOLD;
          end else if (w_pend_any) begin
            w_state_next   = HOLD;
            w_take_pending = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end else begin
          w_count_next = r_count + 8'd1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_count_next = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_count     <= 8'd0;
      r_level_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_level_out <= (w_state_next == HOLD);
      r_overflow  <= w_overflow_next;
    end
  end

  assign level_out = r_level_out;
  assign busy      = (r_state != IDLE);
  assign overflow  = r_overflow;

endmodule
`default_nettype wire
